// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and the
// default sequential increment / reset vector used by inst_fetch.
package ifetch_pkg;

  localparam int unsigned ADDR_W_DEF     = 64;
  localparam int unsigned INST_W_DEF     = 32;
  localparam int unsigned INST_BYTES_DEF = 4;
  localparam logic [63:0] RESET_VEC_DEF  = 64'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Sequential next address; wraps modulo 2^ADDR_W because the sum is
  // truncated to the operand width.
  function automatic logic [63:0] seq_next(input logic [63:0] pc,
                                           input int unsigned incr);
    return pc + 64'(incr);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of PC, instruction-memory, decode and branch-redirect signals seen
// by inst_fetch. The fetch stage uses the slave modport; its environment
// (PC register, imem, decode, execute) uses master.
// Handshake: i_pc_valid is a one-cycle pulse qualifying i_pc_addr; o_imem_cen
// is a one-cycle read request, the read completes in the first cycle after it
// with i_imem_stall low, i_imem_rdata is valid in that cycle; o_inst_valid is
// a one-cycle pulse qualifying o_inst. There is no back-pressure on o_inst.
interface inst_fetch_if
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
);

  logic [ADDR_W-1:0] i_pc_addr;
  logic              i_pc_valid;
  logic [ADDR_W-1:0] o_next_addr;
  logic              o_imem_cen;
  logic [ADDR_W-1:0] o_imem_addr;
  logic              i_imem_stall;
  logic [INST_W-1:0] i_imem_rdata;
  logic [INST_W-1:0] o_inst;
  logic              o_inst_valid;
  logic              i_branch_taken;
  logic [ADDR_W-1:0] i_branch_target;
  logic              o_busy;
  logic              o_overrun;
  state_t            dbg_state;

  modport slave (
    input  i_pc_addr, i_pc_valid, i_imem_stall, i_imem_rdata,
           i_branch_taken, i_branch_target,
    output o_next_addr, o_imem_cen, o_imem_addr, o_inst, o_inst_valid,
           o_busy, o_overrun, dbg_state
  );

  modport master (
    output i_pc_addr, i_pc_valid, i_imem_stall, i_imem_rdata,
           i_branch_taken, i_branch_target,
    input  o_next_addr, o_imem_cen, o_imem_addr, o_inst, o_inst_valid,
           o_busy, o_overrun, dbg_state
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one imem read per PC valid pulse, next-PC generation with
// branch redirect. Optional sticky overrun flag under IFETCH_OVERRUN_CHK_EN.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       INST_W     = INST_W_DEF,
  parameter int unsigned       INST_BYTES = INST_BYTES_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF)
) (
  input logic         i_clk,
  input logic         i_rst_n,
  inst_fetch_if.slave bus
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_addr_q;
  logic [INST_W-1:0] inst_q;
  logic              inst_valid_q;
  logic              accept;
  logic              capture;
  logic              ignored_pulse;

  // A pulse is only taken in IDLE; anywhere else it is dropped.
  assign accept        = (state_q == S_IDLE) && bus.i_pc_valid;
  assign capture       = (state_q == S_WAIT) && !bus.i_imem_stall;
  assign ignored_pulse = (state_q != S_IDLE) && bus.i_pc_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_pc_valid) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (!bus.i_imem_stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q        <= '0;
      next_addr_q <= RESET_VEC;
    end else if (accept) begin
      // Sequential address has priority over a coincident redirect.
      pc_q        <= bus.i_pc_addr;
      next_addr_q <= ADDR_W'(seq_next(64'(bus.i_pc_addr), INST_BYTES));
    end else if (bus.i_branch_taken) begin
      next_addr_q <= bus.i_branch_target;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= capture;
      if (capture) inst_q <= bus.i_imem_rdata;
    end
  end

`ifdef IFETCH_OVERRUN_CHK_EN
  logic overrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           overrun_q <= 1'b0;
    else if (ignored_pulse) overrun_q <= 1'b1;
  end

  assign bus.o_overrun = overrun_q;
`else
  logic unused_ignored;
  assign unused_ignored = ignored_pulse;
  assign bus.o_overrun  = 1'b0;
`endif

  assign bus.o_next_addr  = next_addr_q;
  assign bus.o_imem_cen   = (state_q == S_REQ);
  assign bus.o_imem_addr  = pc_q;
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = inst_valid_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.dbg_state    = state_q;

endmodule
